header_reg_bank: RTL and testbench
==================================

// Module: header_reg_bank
// PURPOSE
//  Sits directly downstream of the UART command interface. Captures its per-word header writes
//  (wr_en/addr/data) into per-core shadow registers, and promotes them to the active header on
//  header_latch. Bumps the timestamp word on inc_time. Starts the hash engine on get_nonce and holds
//  the engine's nonce result until a consumer accepts it.
// PARAMETERS
//  NUM_CORES       1         cores/midstate sets, 1..8 (selected by addr[7:5])
//  WORDS           20        32-bit header words per core (addr[4:0]); word 0 is right-most
//  TIME_IDX        2         word index of the timestamp field
//  TIMEOUT_CYCLES  2**24     RUN watchdog limit; used only with NONCE_TIMEOUT_EN
// PORTS
//  sys_clk        in   1                    system clock
//  rst            in   1                    synchronous active-high reset
//  wr_en          in   1                    shadow word write strobe
//  addr           in   8                    {core[2:0], word[4:0]}
//  data           in   32                   shadow write data
//  header_latch   in   1                    1-cycle pulse: shadow -> active, all cores
//  inc_time       in   1                    1-cycle pulse: active[*][TIME_IDX] += 1
//  get_nonce      in   1                    1-cycle pulse: start engine
//  eng_header     out  NUM_CORES*WORDS*32   active headers; core c word w at [(c*WORDS+w)*32 +: 32]
//  eng_start      out  1                    start request (valid)
//  eng_ready      in   1                    engine accepts start
//  eng_done       in   1                    1-cycle pulse: search finished
//  eng_found      in   1                    qualifies eng_nonce, sampled with eng_done
//  eng_nonce      in   32                   winning nonce
//  res_valid      out  1                    result held for consumer
//  res_ready      in   1                    consumer accepts result
//  res_found      out  1                    result had a nonce
//  res_nonce      out  32                   nonce (0 when !res_found)
//  res_timeout    out  1                    watchdog abort (tied 0 without NONCE_TIMEOUT_EN)
//  busy           out  1                    FSM not IDLE
//  err            out  1                    1-cycle error pulse
// BEHAVIOUR
//  - Reset: every shadow/active word 0; FSM IDLE; hdr_valid=0; pend_latch=0; pend_inc=0.
//    All outputs 0.
//  - Write: when wr_en, word<WORDS and core<NUM_CORES, the shadow word updates next cycle. Any other
//    wr_en drops the write and pulses err. Writes are legal in every state.
//  - Latch outside RUN: the active header takes the whole shadow next cycle, and hdr_valid=1.
//    Latch inside RUN: pend_latch=1.
//  - Time bump outside RUN: the active time word increments modulo 2**32.
//    Time bump inside RUN: pend_inc increments, saturating at 255.
//  - Latch and inc_time in the same cycle, outside RUN: active = shadow, then time word = shadow+1.
//  - FSM: IDLE -> START on get_nonce with hdr_valid. get_nonce with !hdr_valid pulses err and
//    stays in IDLE.
//    START: eng_start=1 until eng_ready is seen in the same cycle. Then RUN; eng_start drops
//    next cycle.
//    RUN: eng_header is frozen. On eng_done: res_found=eng_found, res_nonce=eng_found?eng_nonce:0,
//    go to RESULT.
//    RESULT: res_valid=1 and all res_* are stable until res_valid&&res_ready. Then IDLE and
//    res_valid=0 next cycle.
//  - Entering IDLE from RESULT applies pend_latch first, then adds pend_inc to the time word
//    (modulo 2**32), then clears both, all in one cycle.
//  - get_nonce outside IDLE: ignored, err pulse. eng_done outside RUN: ignored.
//  - Latency: get_nonce to eng_start is 1 cycle. eng_done to res_valid is 1 cycle.
//  - rst mid-operation: everything returns to reset values next cycle. eng_start and res_valid
//    drop with no handshake.
// CONFIGURATION
//  - NONCE_TIMEOUT_EN defined: a 32-bit cycle counter clears on entering RUN.
//    At TIMEOUT_CYCLES with no eng_done: go to RESULT with res_found=0, res_nonce=0, res_timeout=1.
//    eng_done in that same cycle wins, with res_timeout=0.
//  - NONCE_TIMEOUT_EN undefined: no counter; RUN waits indefinitely; res_timeout is constant 0.
// TESTING
//  1. Write addr 0x02=0x5F000000, latch, inc_time x3 -> active[0][2]=0x5F000003.
//  2. NUM_CORES=4: write addr 0x62=0xA5A5A5A5 -> shadow core3 word2. Addr 0x14 or 0x82 -> err
//     pulse, no write.
//  3. get_nonce before any latch -> err, stays IDLE. After latch: eng_ready low 5 cycles ->
//     eng_start held 5 cycles, then RUN.
//  4. RUN plus eng_done with found, nonce 0x1234ABCD, res_ready low 3 cycles -> res_nonce stable
//     3 cycles, then IDLE.
//  5. During RUN: latch (shadow time 0x10) plus inc_time x2 -> header frozen. After the result
//     handshake, time word = 0x12.
//  6. NONCE_TIMEOUT_EN, TIMEOUT_CYCLES=100, no eng_done -> res_valid at RUN+100 with
//     res_timeout=1, res_found=0. Also rst during RESULT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/header_reg_bank.sv
// header_reg_bank: shadow/active header bank with nonce-search handshake FSM.
// Optional RUN watchdog enabled by defining NONCE_TIMEOUT_EN.
module header_reg_bank #(
   parameter int NUM_CORES      = 1,
   parameter int WORDS          = 20,
   parameter int TIME_IDX       = 2,
   parameter int TIMEOUT_CYCLES = 2**24
) (
   input  logic                          sys_clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [7:0]                    addr,
   input  logic [31:0]                   data,
   input  logic                          header_latch,
   input  logic                          inc_time,
   input  logic                          get_nonce,
   output logic [NUM_CORES*WORDS*32-1:0] eng_header,
   output logic                          eng_start,
   input  logic                          eng_ready,
   input  logic                          eng_done,
   input  logic                          eng_found,
   input  logic [31:0]                   eng_nonce,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic                          res_found,
   output logic [31:0]                   res_nonce,
   output logic                          res_timeout,
   output logic                          busy,
   output logic                          err
);
   typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_RESULT} state_t;
   state_t r_state, w_next;
   logic [31:0] r_shadow [NUM_CORES][WORDS];
   logic [31:0] r_active [NUM_CORES][WORDS];
   logic [31:0] w_active [NUM_CORES][WORDS];
   logic        r_hdr_valid, r_pend_latch, r_err, r_found;
   logic [7:0]  r_pend_inc;
   logic [31:0] r_nonce, w_add;
   logic        w_wr_ok, w_run, w_exit, w_take, w_tmo;

   assign w_wr_ok = ({1'b0, addr[4:0]} < 6'(WORDS)) && ({1'b0, addr[7:5]} < 4'(NUM_CORES));
   assign w_run   = r_state == S_RUN;
   assign w_exit  = r_state == S_RESULT && res_ready;
   // Leaving RESULT replays a latch deferred during RUN, then the deferred time bumps.
   assign w_take  = (!w_run && header_latch) || (w_exit && r_pend_latch);
   assign w_add   = w_run ? 32'd0 : {24'd0, w_exit ? r_pend_inc : 8'd0} + {31'd0, inc_time};

   always_comb begin
      for (int c = 0; c < NUM_CORES; c++)
         for (int w = 0; w < WORDS; w++)
            w_active[c][w] = (w_take ? r_shadow[c][w] : r_active[c][w]) + (w == TIME_IDX ? w_add : 32'd0);
   end

   always_ff @(posedge sys_clk) begin
      for (int c = 0; c < NUM_CORES; c++)
         for (int w = 0; w < WORDS; w++) begin
            if (rst) begin
               r_shadow[c][w] <= '0;
               r_active[c][w] <= '0;
            end else begin
               if (w_wr_ok && wr_en && addr[7:5] == 3'(c) && addr[4:0] == 5'(w)) r_shadow[c][w] <= data;
               if (!w_run) r_active[c][w] <= w_active[c][w];
            end
         end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_hdr_valid  <= 1'b0;
         r_pend_latch <= 1'b0;
         r_pend_inc   <= '0;
         r_err        <= 1'b0;
         r_found      <= 1'b0;
         r_nonce      <= '0;
      end else begin
         r_hdr_valid  <= r_hdr_valid || w_take;
         r_pend_latch <= w_exit ? 1'b0 : r_pend_latch || (w_run && header_latch);
         r_pend_inc   <= w_exit ? 8'd0 : r_pend_inc + 8'(w_run && inc_time && r_pend_inc != 8'hFF);
         r_err        <= (wr_en && !w_wr_ok) || (get_nonce && (r_state != S_IDLE || !r_hdr_valid));
         if (w_run && eng_done) begin
            r_found <= eng_found;
            r_nonce <= eng_found ? eng_nonce : 32'd0;
         end else if (w_tmo) begin
            r_found <= 1'b0;
            r_nonce <= '0;
         end
      end
   end

`ifdef NONCE_TIMEOUT_EN
   logic [31:0] r_cnt;
   logic        r_timeout;
   assign w_tmo       = w_run && r_cnt == 32'(TIMEOUT_CYCLES - 1);
   assign res_timeout = r_timeout;
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_cnt <= w_run ? r_cnt + 32'd1 : 32'd0;
         if (w_run && eng_done) r_timeout <= 1'b0;
         else if (w_tmo) r_timeout <= 1'b1;
      end
   end
`else
   assign w_tmo       = 1'b0 && TIMEOUT_CYCLES > 0;
   assign res_timeout = 1'b0;
`endif

   always_ff @(posedge sys_clk) begin
      if (rst) r_state <= S_IDLE;
      else r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = (get_nonce && r_hdr_valid) ? S_START : S_IDLE;
         S_START:  w_next = eng_ready ? S_RUN : S_START;
         S_RUN:    w_next = (eng_done || w_tmo) ? S_RESULT : S_RUN;
         S_RESULT: w_next = res_ready ? S_IDLE : S_RESULT;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      eng_start = r_state == S_START;
      res_valid = r_state == S_RESULT;
      busy      = r_state != S_IDLE;
   end

   assign res_found = r_found;
   assign res_nonce = r_nonce;
   assign err       = r_err;

   for (genvar c = 0; c < NUM_CORES; c++) begin : g_c
      for (genvar w = 0; w < WORDS; w++) begin : g_w
         assign eng_header[(c*WORDS+w)*32 +: 32] = r_active[c][w];
      end
   end
endmodule

// File: tb/tb_header_reg_bank.sv
// tb_header_reg_bank: directed bench for header_reg_bank with four cores.
module tb_header_reg_bank;
   localparam int NC = 4;
   logic              sys_clk, rst, wr_en, header_latch, inc_time, get_nonce;
   logic [7:0]        addr;
   logic [31:0]       data, eng_nonce, res_nonce;
   logic [NC*640-1:0] eng_header;
   logic              eng_start, eng_ready, eng_done, eng_found;
   logic              res_valid, res_ready, res_found, res_timeout, busy, err;
   int                n_tests = 0, n_fail = 0;

   header_reg_bank #(.NUM_CORES(NC), .TIMEOUT_CYCLES(100)) dut (
      .sys_clk(sys_clk), .rst(rst), .wr_en(wr_en), .addr(addr), .data(data),
      .header_latch(header_latch), .inc_time(inc_time), .get_nonce(get_nonce),
      .eng_header(eng_header), .eng_start(eng_start), .eng_ready(eng_ready),
      .eng_done(eng_done), .eng_found(eng_found), .eng_nonce(eng_nonce),
      .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found),
      .res_nonce(res_nonce), .res_timeout(res_timeout), .busy(busy), .err(err)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   function automatic logic [31:0] act(input int c, input int w);
      return 32'(eng_header >> ((c * 20 + w) * 32));
   endfunction

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      wr_en = 1'b1; addr = a; data = d;
      tick();
      wr_en = 1'b0;
   endtask

   initial begin
      int bad;
      {rst, wr_en, header_latch, inc_time, get_nonce, eng_ready, eng_done, eng_found, res_ready} = '1;
      {wr_en, header_latch, inc_time, get_nonce, eng_ready, eng_done, eng_found, res_ready} = '0;
      addr = '0; data = '0; eng_nonce = '0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_start", 32'(eng_start), 0);
      chk("rst_valid", 32'(res_valid), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_hdr_zero", 32'(eng_header == '0), 1);
      // get_nonce before any latch
      get_nonce = 1'b1; tick(); get_nonce = 1'b0;
      chk("nohdr_err", 32'(err), 1);
      chk("nohdr_idle", 32'(busy), 0);
      tick();
      chk("err_one_cycle", 32'(err), 0);
      // latch then three time bumps
      wr(8'h02, 32'h5F000000);
      header_latch = 1'b1; tick(); header_latch = 1'b0;
      chk("latch_time", act(0, 2), 32'h5F000000);
      inc_time = 1'b1; tick(); tick(); tick(); inc_time = 1'b0;
      chk("inc_x3", act(0, 2), 32'h5F000003);
      chk("inc_x3_core1", act(1, 2), 32'h3);
      // core addressing and illegal writes
      wr(8'h62, 32'hA5A5A5A5);
      chk("good_wr_err", 32'(err), 0);
      wr(8'h14, 32'hFFFFFFFF);
      chk("bad_word_err", 32'(err), 1);
      wr(8'h82, 32'hFFFFFFFF);
      chk("bad_core_err", 32'(err), 1);
      header_latch = 1'b1; tick(); header_latch = 1'b0;
      chk("core3_w2", act(3, 2), 32'hA5A5A5A5);
      chk("core0_w2", act(0, 2), 32'h5F000000);
      bad = 0;
      for (int c = 0; c < NC; c++)
         for (int w = 0; w < 20; w++)
            if (!((c == 0 || c == 3) && w == 2) && act(c, w) !== 32'd0) bad++;
      chk("no_stray_write", 32'(bad), 0);
      // start handshake with eng_ready held off
      get_nonce = 1'b1; tick(); get_nonce = 1'b0;
      chk("start_lat1", 32'(eng_start), 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("start_held", 32'(eng_start), 1);
      end
      eng_ready = 1'b1; tick(); eng_ready = 1'b0;
      chk("start_drop", 32'(eng_start), 0);
      chk("run_busy", 32'(busy), 1);
      // header frozen while running
      wr(8'h02, 32'h00000010);
      header_latch = 1'b1; tick(); header_latch = 1'b0;
      inc_time = 1'b1; tick(); tick(); inc_time = 1'b0;
      chk("frozen_c0", act(0, 2), 32'h5F000000);
      chk("frozen_c3", act(3, 2), 32'hA5A5A5A5);
      get_nonce = 1'b1; tick(); get_nonce = 1'b0;
      chk("run_getnonce_err", 32'(err), 1);
      // found result held under backpressure
      eng_done = 1'b1; eng_found = 1'b1; eng_nonce = 32'h1234ABCD;
      tick();
      eng_done = 1'b0; eng_found = 1'b0; eng_nonce = 32'h0BADF00D;
      chk("res_valid", 32'(res_valid), 1);
      chk("res_found", 32'(res_found), 1);
      chk("res_to", 32'(res_timeout), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("res_nonce_hold", res_nonce, 32'h1234ABCD);
         chk("res_valid_hold", 32'(res_valid), 1);
      end
      res_ready = 1'b1; tick(); res_ready = 1'b0;
      chk("back_idle", 32'(busy), 0);
      chk("valid_drop", 32'(res_valid), 0);
      chk("pend_c0", act(0, 2), 32'h00000012);
      chk("pend_c3", act(3, 2), 32'hA5A5A5A7);
      chk("pend_c1", act(1, 2), 32'h00000002);
      // eng_done in IDLE is ignored
      eng_done = 1'b1; eng_found = 1'b1; tick(); eng_done = 1'b0; eng_found = 1'b0;
      chk("idle_done_ign", 32'(res_valid), 0);
      // latch and bump together, with wrap
      wr(8'h02, 32'hFFFFFFFF);
      header_latch = 1'b1; inc_time = 1'b1; tick(); header_latch = 1'b0; inc_time = 1'b0;
      chk("wrap_c0", act(0, 2), 32'h0);
      chk("wrap_c3", act(3, 2), 32'hA5A5A5A6);
      // not-found result then reset during RESULT
      get_nonce = 1'b1; eng_ready = 1'b1; tick(); get_nonce = 1'b0;
      tick(); eng_ready = 1'b0;
      chk("run2_busy", 32'(busy), 1);
      eng_done = 1'b1; eng_nonce = 32'hDEADBEEF; tick(); eng_done = 1'b0;
      chk("nf_valid", 32'(res_valid), 1);
      chk("nf_found", 32'(res_found), 0);
      chk("nf_nonce", res_nonce, 32'h0);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_res_busy", 32'(busy), 0);
      chk("rst_res_hdr", 32'(eng_header == '0), 1);
      chk("rst_res_to", 32'(res_timeout), 0);
`ifdef NONCE_TIMEOUT_EN
      wr(8'h02, 32'h1);
      header_latch = 1'b1; tick(); header_latch = 1'b0;
      get_nonce = 1'b1; eng_ready = 1'b1; tick(); get_nonce = 1'b0;
      tick(); eng_ready = 1'b0;
      for (int i = 0; i < 99; i++) tick();
      chk("to_not_yet", 32'(res_valid), 0);
      tick();
      chk("to_valid", 32'(res_valid), 1);
      chk("to_flag", 32'(res_timeout), 1);
      chk("to_found", 32'(res_found), 0);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("to_rst_valid", 32'(res_valid), 0);
      chk("to_rst_flag", 32'(res_timeout), 0);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
